// File: rtl/s10_acp_csr_programmer.sv
// Avalon-MM initiator that programs the S10 ACP adapter attribute register through a
// field-masked read-modify-write, with optional readback verify, bounded retry and a shadow copy.
module s10_acp_csr_programmer #(
    parameter int          READ_LATENCY  = 1,
    parameter int          MAX_RETRY     = 2,
    parameter logic [31:0] RESERVED_MASK = 32'h1F80_0000,
    parameter logic [31:0] SHADOW_INIT   = 32'h6078_2F02
) (
    input  logic        csr_clk,
    input  logic        csr_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_mask,
    input  logic [31:0] req_data,
    input  logic        req_verify,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_error,
    output logic [31:0] rsp_readdata,
    output logic        avm_addr,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic [31:0] shadow,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_WAIT, S_WR, S_VRD, S_VRD_WAIT, S_RSP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  lat_cnt;
    logic [2:0]  retry_cnt;
    logic [31:0] mask_q;
    logic [31:0] data_q;
    logic        verify_q;
    logic [31:0] new_q;
    logic [31:0] merged;
    logic        lat_done;
    logic        rb_match;
    logic        retry_left;

    assign lat_done   = (lat_cnt == 3'(READ_LATENCY - 1));
    assign merged     = ((avm_readdata & ~mask_q) | (data_q & mask_q)) & ~RESERVED_MASK;
    assign rb_match   = ((avm_readdata & ~RESERVED_MASK) == new_q);
    assign retry_left = (retry_cnt < 3'(MAX_RETRY));

    assign req_ready     = (state == S_IDLE);
    assign rsp_valid     = (state == S_RSP);
    assign busy          = (state != S_IDLE);
    assign avm_addr      = 1'b0;
    assign avm_read      = (state == S_RD) || (state == S_VRD);
    assign avm_write     = (state == S_WR);
    assign avm_writedata = new_q;

    always_ff @(posedge csr_clk or posedge csr_reset) begin
        if (csr_reset) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (req_valid) state_nxt = S_RD;
            S_RD:       state_nxt = S_RD_WAIT;
            S_RD_WAIT:  if (lat_done) state_nxt = (mask_q == 32'h0) ? S_RSP : S_WR;
            S_WR:       state_nxt = verify_q ? S_VRD : S_RSP;
            S_VRD:      state_nxt = S_VRD_WAIT;
            S_VRD_WAIT: if (lat_done) state_nxt = (!rb_match && retry_left) ? S_WR : S_RSP;
            S_RSP:      if (rsp_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Request latch, merge, verify bookkeeping and shadow update; all abort on reset.
    always_ff @(posedge csr_clk or posedge csr_reset) begin
        if (csr_reset) begin
            lat_cnt      <= 3'd0;
            retry_cnt    <= 3'd0;
            mask_q       <= 32'h0;
            data_q       <= 32'h0;
            verify_q     <= 1'b0;
            new_q        <= 32'h0;
            rsp_error    <= 1'b0;
            rsp_readdata <= 32'h0;
            shadow       <= SHADOW_INIT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        mask_q    <= req_mask;
                        data_q    <= req_data;
                        verify_q  <= req_verify;
                        rsp_error <= 1'b0;
                    end
                end
                S_RD, S_VRD: lat_cnt <= 3'd0;
                S_RD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_done) begin
                        new_q <= merged;
                        if (mask_q == 32'h0) begin
                            rsp_readdata <= avm_readdata;
                            shadow       <= avm_readdata & ~RESERVED_MASK;
                        end
                    end
                end
                S_WR: begin
                    if (!verify_q) begin
                        shadow       <= new_q;
                        rsp_readdata <= new_q;
                    end
                end
                S_VRD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_done) begin
                        rsp_readdata <= avm_readdata;
                        if (rb_match) begin
                            shadow    <= new_q;
                            rsp_error <= 1'b0;
                        end else if (retry_left) begin
                            retry_cnt <= retry_cnt + 3'd1;
                        end else begin
                            rsp_error <= 1'b1;
                        end
                    end
                end
                S_RSP: if (rsp_ready) retry_cnt <= 3'd0;
                default: ;
            endcase
        end
    end

endmodule
